// File: rtl/pa_core_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses, cause codes,
// mstatus field positions and state encoding.
package pa_core_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Exception codes (interrupt flag is carried separately in the cause MSB)
    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_EBREAK  = 5'd3;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;
    localparam logic [4:0] CAUSE_IRQ_TMR = 5'd7;
    localparam logic [4:0] CAUSE_IRQ_EXT = 5'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_T_MEPC    = 3'd1;
    localparam logic [2:0] ST_T_MCAUSE  = 3'd2;
    localparam logic [2:0] ST_T_MSTATUS = 3'd3;
    localparam logic [2:0] ST_R_MSTATUS = 3'd4;
    localparam logic [2:0] ST_JUMP      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_T_MEPC    = ST_T_MEPC,
        S_T_MCAUSE  = ST_T_MCAUSE,
        S_T_MSTATUS = ST_T_MSTATUS,
        S_R_MSTATUS = ST_R_MSTATUS,
        S_JUMP      = ST_JUMP
    } trap_state_e;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_EXC  = 2'd1,
        REQ_IRQ  = 2'd2,
        REQ_MRET = 2'd3
    } trap_req_e;

endpackage

// File: rtl/pa_core_trap_ctrl_prio.sv
// Combinational request arbiter: picks exception > enabled interrupt > MRET and
// builds the matching mcause value.
module pa_core_trap_prio
    import pa_core_trap_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              exc_ecall_i,
    input  logic              exc_ebreak_i,
    input  logic              exc_illegal_i,
    input  logic              mret_i,
    input  logic              irq_ext_i,
    input  logic              irq_tmr_i,
    input  logic              mie_i,
    output logic              accept_o,
    output trap_req_e         req_o,
    output logic [DATA_W-1:0] cause_o
);

    logic [4:0] code_s;
    logic       irq_s;

    // Priority encoder over all trap/return sources
    always_comb begin
        req_o  = REQ_NONE;
        code_s = 5'd0;
        irq_s  = 1'b0;
        if (exc_illegal_i) begin
            req_o  = REQ_EXC;
            code_s = CAUSE_ILLEGAL;
        end else if (exc_ebreak_i) begin
            req_o  = REQ_EXC;
            code_s = CAUSE_EBREAK;
        end else if (exc_ecall_i) begin
            req_o  = REQ_EXC;
            code_s = CAUSE_ECALL;
        end else if (mie_i && irq_ext_i) begin
            req_o  = REQ_IRQ;
            code_s = CAUSE_IRQ_EXT;
            irq_s  = 1'b1;
        end else if (mie_i && irq_tmr_i) begin
            req_o  = REQ_IRQ;
            code_s = CAUSE_IRQ_TMR;
            irq_s  = 1'b1;
        end else if (mret_i) begin
            req_o  = REQ_MRET;
        end else begin
            req_o  = REQ_NONE;
        end
    end

    assign accept_o = (req_o != REQ_NONE);
    assign cause_o  = {irq_s, {(DATA_W-6){1'b0}}, code_s};

endmodule

// File: rtl/pa_core_trap_ctrl.sv
// Trap sequencer owning the machine-mode CSR write port: passes execute writes through
// when idle, otherwise sequences mepc/mcause/mstatus updates and redirects the PC.
// Build option: TRAP_VECTORED_EN enables vectored interrupt targets (mtvec mode 01).
module pa_core_trap_ctrl
    import pa_core_trap_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CSR_W  = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              exc_ecall_i,
    input  logic              exc_ebreak_i,
    input  logic              exc_illegal_i,
    input  logic              mret_i,
    input  logic              irq_ext_i,
    input  logic              irq_tmr_i,
    input  logic [CSR_W-1:0]  ex_csr_waddr_i,
    input  logic              ex_csr_wvld_i,
    input  logic [DATA_W-1:0] ex_csr_wdata_i,
    input  logic [DATA_W-1:0] csr_mtvec_i,
    input  logic [DATA_W-1:0] csr_mepc_i,
    input  logic [DATA_W-1:0] csr_mstatus_i,
    output logic [CSR_W-1:0]  csr_waddr_o,
    output logic              csr_waddr_vld_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              hold_o,
    output logic              jump_o,
    output logic [DATA_W-1:0] jump_addr_o
);

    function automatic logic [DATA_W-1:0] mstatus_on_trap(input logic [DATA_W-1:0] m);
        logic [DATA_W-1:0] r;
        r                                = m;
        r[MSTATUS_MPIE]                  = m[MSTATUS_MIE];
        r[MSTATUS_MIE]                   = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] mstatus_on_mret(input logic [DATA_W-1:0] m);
        logic [DATA_W-1:0] r;
        r                                = m;
        r[MSTATUS_MIE]                   = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                  = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    trap_state_e       state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] cause_q, cause_d;
    logic              mret_q, mret_d;

    logic              accept_s;
    trap_req_e         req_s;
    logic [DATA_W-1:0] cause_s;
    logic [CSR_W-1:0]  waddr_s;
    logic              wvld_s;
    logic [DATA_W-1:0] wdata_s;
    logic              hold_s;
    logic              jump_s;
    logic [DATA_W-1:0] jaddr_s;
    logic [DATA_W-1:0] trap_base_s;
    logic [DATA_W-1:0] trap_tgt_s;

    pa_core_trap_prio #(
        .DATA_W (DATA_W)
    ) u_prio (
        .exc_ecall_i   (exc_ecall_i),
        .exc_ebreak_i  (exc_ebreak_i),
        .exc_illegal_i (exc_illegal_i),
        .mret_i        (mret_i),
        .irq_ext_i     (irq_ext_i),
        .irq_tmr_i     (irq_tmr_i),
        .mie_i         (csr_mstatus_i[MSTATUS_MIE]),
        .accept_o      (accept_s),
        .req_o         (req_s),
        .cause_o       (cause_s)
    );

    assign trap_base_s = {csr_mtvec_i[DATA_W-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Vectored mode applies to interrupts only; exceptions always land on the base
    always_comb begin
        if ((csr_mtvec_i[1:0] == 2'b01) && cause_q[DATA_W-1]) begin
            trap_tgt_s = trap_base_s + {{(DATA_W-7){1'b0}}, cause_q[4:0], 2'b00};
        end else begin
            trap_tgt_s = trap_base_s;
        end
    end
`else
    logic mtvec_mode_unused_s;
    assign mtvec_mode_unused_s = ^csr_mtvec_i[1:0];
    assign trap_tgt_s          = trap_base_s;
`endif

    // State and latched trap context
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            pc_q    <= {DATA_W{1'b0}};
            cause_q <= {DATA_W{1'b0}};
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            mret_q  <= mret_d;
        end
    end

    // Next-state logic and CSR write-port mux
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        mret_d  = mret_q;
        waddr_s = {CSR_W{1'b0}};
        wvld_s  = 1'b0;
        wdata_s = {DATA_W{1'b0}};
        hold_s  = 1'b0;
        jump_s  = 1'b0;
        jaddr_s = {DATA_W{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    hold_s  = 1'b1;
                    pc_d    = pc_i;
                    cause_d = cause_s;
                    if (req_s == REQ_MRET) begin
                        mret_d  = 1'b1;
                        state_d = S_R_MSTATUS;
                    end else begin
                        mret_d  = 1'b0;
                        state_d = S_T_MEPC;
                    end
                end else begin
                    waddr_s = ex_csr_waddr_i;
                    wvld_s  = ex_csr_wvld_i;
                    wdata_s = ex_csr_wdata_i;
                end
            end
            S_T_MEPC: begin
                hold_s  = 1'b1;
                waddr_s = CSR_W'(CSR_MEPC);
                wvld_s  = 1'b1;
                wdata_s = pc_q;
                state_d = S_T_MCAUSE;
            end
            S_T_MCAUSE: begin
                hold_s  = 1'b1;
                waddr_s = CSR_W'(CSR_MCAUSE);
                wvld_s  = 1'b1;
                wdata_s = cause_q;
                state_d = S_T_MSTATUS;
            end
            S_T_MSTATUS: begin
                hold_s  = 1'b1;
                waddr_s = CSR_W'(CSR_MSTATUS);
                wvld_s  = 1'b1;
                wdata_s = mstatus_on_trap(csr_mstatus_i);
                state_d = S_JUMP;
            end
            S_R_MSTATUS: begin
                hold_s  = 1'b1;
                waddr_s = CSR_W'(CSR_MSTATUS);
                wvld_s  = 1'b1;
                wdata_s = mstatus_on_mret(csr_mstatus_i);
                state_d = S_JUMP;
            end
            S_JUMP: begin
                hold_s  = 1'b1;
                jump_s  = 1'b1;
                jaddr_s = mret_q ? csr_mepc_i : trap_tgt_s;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs forced low while reset is asserted, even though the idle path is combinational
    assign csr_waddr_o     = rst_n_i ? waddr_s : {CSR_W{1'b0}};
    assign csr_waddr_vld_o = rst_n_i & wvld_s;
    assign csr_wdata_o     = rst_n_i ? wdata_s : {DATA_W{1'b0}};
    assign hold_o          = rst_n_i & hold_s;
    assign jump_o          = rst_n_i & jump_s;
    assign jump_addr_o     = rst_n_i ? jaddr_s : {DATA_W{1'b0}};

endmodule

// File: doc/pa_core_trap_ctrl.md
Name: pa_core_trap_ctrl

Overview:
Trap sequencer sitting directly upstream of the machine-mode CSR register file; it owns that file's single write port.
- Idle: passes execute-stage CSR writes through unchanged.
- Exception, enabled interrupt or MRET: holds the pipeline, writes mepc/mcause/mstatus over successive cycles, then redirects the PC.
- Consumes the CSR file's mtvec/mepc/mstatus outputs.

Parameters:
DATA_W, 32, data/CSR value width (DATA_BUS_WIDTH)
CSR_W, 12, CSR address width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
pc_i  in  DATA_W  PC of instruction currently in execute
exc_ecall_i  in  1  ECALL in execute
exc_ebreak_i  in  1  EBREAK in execute
exc_illegal_i  in  1  illegal instruction in execute
mret_i  in  1  MRET in execute
irq_ext_i  in  1  external interrupt, level
irq_tmr_i  in  1  timer interrupt, level
ex_csr_waddr_i  in  CSR_W  execute-stage CSR write address
ex_csr_wvld_i  in  1  execute-stage CSR write valid
ex_csr_wdata_i  in  DATA_W  execute-stage CSR write data
csr_mtvec_i  in  DATA_W  current mtvec
csr_mepc_i  in  DATA_W  current mepc
csr_mstatus_i  in  DATA_W  current mstatus
csr_waddr_o  out  CSR_W  write address to CSR file
csr_waddr_vld_o  out  1  write valid to CSR file
csr_wdata_o  out  DATA_W  write data to CSR file
hold_o  out  1  stall fetch/decode/execute
jump_o  out  1  one-cycle PC redirect strobe
jump_addr_o  out  DATA_W  redirect target

Behaviour:
- Reset (asynchronous): state=IDLE, all outputs 0, latched pc/cause 0.
- States: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, R_MSTATUS, JUMP.
- IDLE acceptance priority: exception > interrupt > MRET.
  - Exception sub-priority: illegal (cause 2) > ebreak (3) > ecall (11).
  - Interrupt accepted only if csr_mstatus_i[3] (MIE)=1. External (0x8000000B) beats timer (0x80000007).
- On any accept:
  - Latch pc_i and cause.
  - Suppress that cycle's ex CSR write; the instruction does not retire.
  - hold_o=1 combinationally in the same cycle.
- No accept in IDLE: csr_*_o mirror ex_csr_*_i; hold_o=0.
- Trap path: T_MEPC -> T_MCAUSE -> T_MSTATUS -> JUMP.
  - T_MEPC writes mepc=latched pc.
  - T_MCAUSE writes mcause=latched cause.
  - T_MSTATUS writes csr_mstatus_i with MPIE(bit7)=MIE(bit3), MIE=0, MPP(12:11)=2'b11.
- MRET path: R_MSTATUS -> JUMP. R_MSTATUS writes mstatus with MIE=MPIE, MPIE=1, MPP=2'b11.
- JUMP:
  - jump_o=1 and hold_o=1 for exactly one cycle; csr_waddr_vld_o=0; next state IDLE.
  - Trap target: {csr_mtvec_i[31:2],2'b00}, sampled in JUMP.
  - MRET target: csr_mepc_i.
- Trap latency: 4 cycles from accept to jump strobe. MRET latency: 2 cycles.
- Non-IDLE states:
  - hold_o=1; ex inputs and new requests ignored. Upstream holds requests; interrupts are level.
  - jump_addr_o=0 except in JUMP.
- Simultaneous exception+MRET flags: treated as exception.
- Interrupt arriving during a sequence: evaluated on return to IDLE, using the updated MIE.
- Reset mid-sequence: abort to IDLE; partially written CSRs are not restored.

Optional Feature:
TRAP_VECTORED_EN
- Defined: when csr_mtvec_i[1:0]==2'b01 and the latched cause is an interrupt, target = {mtvec[31:2],2'b00} + 4*cause[4:0]. Exceptions always use the base.
- Undefined: mtvec[1:0] ignored; all traps go to the base.

Decomposition:
- Shared package/header (alongside chip_param):
  - CSR addresses (MEPC, MCAUSE, MSTATUS).
  - Cause codes.
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - State encoding localparams.
- Sub-module: pa_core_trap_prio, combinational priority/cause encoder producing accept, type and cause.
- FSM and write mux stay in the top module.

Test Plan:
- ECALL at pc_i=0x100, mtvec=0x200, mstatus=0x8 -> writes mepc=0x100, mcause=11, mstatus=0x1880 on consecutive cycles; jump_o at cycle 4 to 0x200; hold_o high cycles 0-4.
- MRET with mepc=0x104, mstatus=0x1880 -> mstatus write 0x1888; jump_o next cycle to 0x104.
- irq_tmr_i=1 with MIE=0 -> no accept, ex writes pass through. Set MIE=1 -> mcause=0x80000007, mepc=pc_i.
- ex_csr_wvld_i=1 (mscratch, 0xDEAD) in the same cycle as exc_illegal_i -> no mscratch write; mcause=2.
- irq_ext_i and irq_tmr_i together with exc_ebreak_i -> mcause=3. After JUMP, MIE=0, so no interrupt is taken.
- TRAP_VECTORED_EN, mtvec=0x201, external interrupt -> target 0x22C. Same with macro undefined -> 0x200. Reset asserted in T_MCAUSE -> all outputs 0, state IDLE.
